adc_serial_responder: RTL and testbench
=======================================

// Module: adc_serial_responder
// PURPOSE
// - Slave end of the 16-bit ADC serial frame used by the adc sampling master: a synthesizable
//   model of the AD79x8-style converter for loopback test and board bring-up without silicon.
// - Captures the master's control word from din while cs_n is low, returns {0, ADD[2:0], DATA[11:0]}
//   MSB-first on dout, and applies WRITE frames to its internal control register.
// - Same clk as the master (master samples dout and drives din on clk rising edges).
// PARAMETERS
// - FRAME_BITS  16     bits per frame
// - DATA_BITS   12     conversion result width
// - ADDR_BITS   3      channel address width
// - RESET_PM    2'b11  power mode after reset (11 normal)
// PORTS
// - clk          in   1   system/serial clock
// - reset        in   1   asynchronous, active-high
// - cs_n         in   1   frame select from master, active-low
// - din          in   1   control word bit from master, MSB first
// - dout         out  1   result bit to master, MSB first
// - sample       in   12  conversion value for channel chan, supplied by test/sample source
// - chan         out  3   channel converted in the next frame
// - cfg_pm       out  2   current power mode
// - cfg_range    out  1   current RANGE bit
// - cfg_coding   out  1   current CODING bit
// - frame_done   out  1   one-cycle pulse: full 16-bit frame completed
// - frame_abort  out  1   one-cycle pulse: cs_n rose before 16 bits
// BEHAVIOUR
// - Reset: dout=0, chan=0, cfg_pm=RESET_PM, cfg_range=0, cfg_coding=0, seq state off, bit count 0,
//   frame_done=0, frame_abort=0, state IDLE. Reset mid-frame discards the frame, no pulses.
// - States: IDLE, SHIFT, DONE.
// - IDLE (cs_n high): out_sr reloads every cycle with {1'b0, chan, data}; data = sample, or 12'h000
//   when cfg_pm==2'b10 (shutdown). dout = out_sr[15] (registered). cs_n low at a posedge -> SHIFT.
// - SHIFT: each posedge with cs_n low: in_sr <= {in_sr[14:0], din}; out_sr shifts left, 0 fills;
//   count++. At the 16th edge -> DONE. cs_n high before that -> frame_abort pulse, IDLE, nothing
//   applied.
// - DONE (one cycle): frame_done=1; decode in_sr; then IDLE once cs_n is high (extra clocks with
//   cs_n low: dout=0, din ignored, no second frame until cs_n has been high at least one cycle).
// - Control word in_sr[15:0]: 15 WRITE, 14 SEQ, 12:10 ADD, 9:8 PM, 7 SHADOW, 5 RANGE, 4 CODING;
//   13, 6, 3:0 don't care.
// - WRITE=0: control register and channel logic unchanged, except sequence advance below.
// - WRITE=1: cfg_pm/cfg_range/cfg_coding <= PM/RANGE/CODING.
//   SEQ=0 or SHADOW=1: chan <= ADD, sequencing off.
//   SEQ=1 and SHADOW=0: seq_last <= ADD, chan <= 0, sequencing on.
// - Sequencing on, completed frame with WRITE=0: chan <= (chan==seq_last) ? 0 : chan+1.
// - Latency: first dout bit valid before the first shifting edge; new config/chan visible the
//   cycle after frame_done and used by the next frame's preload.
// - frame_done and frame_abort never assert together; chan only changes in DONE or reset.
// STRUCTURE
// - Shared package: field bit positions (WRITE, SEQ, ADD_HI/LO, PM_HI/LO, SHADOW, RANGE, CODING),
//   PM encodings (PM_NORMAL=2'b11, PM_SHUTDOWN=2'b10), state typedef; shared with the master.
// - One sub-module natural: adc_ctrl_decode (in_sr + current cfg -> next cfg/chan/seq state).
// TESTING
// - Reset asserted at bit 7 of a frame -> all outputs at reset values, no done/abort pulse.
// - Reset, sample=12'hABC, frame din=16'h8700 -> dout stream 16'h0ABC, frame_done, chan=1, pm=11.
// - Then sample=12'h123, din=16'h0700 -> dout 16'h1123, chan stays 1, config unchanged.
// - cs_n high after 8 bits of din=16'h8F00 -> frame_abort pulse, chan/cfg unchanged, next frame ok.
// - din=16'h8600 (ADD=1, PM=10) then any frame -> dout 16'h1000 (data zeroed in shutdown).
// - din=16'hCF00 (SEQ=1, ADD=3) then 5 frames with 16'h0300 -> address fields 0,1,2,3,0 on dout.

Source files
------------

// File: rtl/adc_serial_responder_pkg.sv
// Shared definitions for the ADC serial frame: control word field
// positions, power mode encodings and the frame state type.
package adc_serial_responder_pkg;

    localparam int WRITE_BIT  = 15;
    localparam int SEQ_BIT    = 14;
    localparam int ADD_HI     = 12;
    localparam int ADD_LO     = 10;
    localparam int PM_HI      = 9;
    localparam int PM_LO      = 8;
    localparam int SHADOW_BIT = 7;
    localparam int RANGE_BIT  = 5;
    localparam int CODING_BIT = 4;

    localparam logic [1:0] PM_NORMAL   = 2'b11;
    localparam logic [1:0] PM_SHUTDOWN = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/adc_ctrl_decode.sv
// Control word decoder: captured word plus current control state
// gives the control state to apply when a frame completes.
module adc_ctrl_decode
    import adc_serial_responder_pkg::*;
(
    input  logic [15:0] word,
    input  logic [1:0]  pm,
    input  logic        range,
    input  logic        coding,
    input  logic [2:0]  chan,
    input  logic        seq_on,
    input  logic [2:0]  seq_last,
    output logic [1:0]  pm_nxt,
    output logic        range_nxt,
    output logic        coding_nxt,
    output logic [2:0]  chan_nxt,
    output logic        seq_on_nxt,
    output logic [2:0]  seq_last_nxt
);

    logic unused_bits;
    assign unused_bits = ^{word[13], word[6], word[3:0]};

    // Write frames load config and channel; reads only step the sequencer.
    always_comb begin
        pm_nxt       = pm;
        range_nxt    = range;
        coding_nxt   = coding;
        chan_nxt     = chan;
        seq_on_nxt   = seq_on;
        seq_last_nxt = seq_last;
        if (word[WRITE_BIT]) begin
            pm_nxt     = word[PM_HI:PM_LO];
            range_nxt  = word[RANGE_BIT];
            coding_nxt = word[CODING_BIT];
            if (word[SEQ_BIT] && !word[SHADOW_BIT]) begin
                seq_last_nxt = word[ADD_HI:ADD_LO];
                chan_nxt     = 3'd0;
                seq_on_nxt   = 1'b1;
            end else begin
                chan_nxt   = word[ADD_HI:ADD_LO];
                seq_on_nxt = 1'b0;
            end
        end else if (seq_on) begin
            chan_nxt = (chan == seq_last) ? 3'd0 : chan + 3'd1;
        end
    end

endmodule

// File: rtl/adc_serial_responder.sv
// Slave end of the 16-bit ADC serial frame: shifts the control word
// in on din, the {0, ADD, DATA} result out on dout, applies writes.
module adc_serial_responder
    import adc_serial_responder_pkg::*;
#(
    parameter int         FRAME_BITS = 16,
    parameter int         DATA_BITS  = 12,
    parameter int         ADDR_BITS  = 3,
    parameter logic [1:0] RESET_PM   = PM_NORMAL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 din,
    output logic                 dout,
    input  logic [DATA_BITS-1:0] sample,
    output logic [ADDR_BITS-1:0] chan,
    output logic [1:0]           cfg_pm,
    output logic                 cfg_range,
    output logic                 cfg_coding,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         count;
    logic [FRAME_BITS-1:0] in_sr;
    logic [FRAME_BITS-1:0] out_sr;
    logic [FRAME_BITS-1:0] load;
    logic [DATA_BITS-1:0]  data;
    logic                  seq_on;
    logic [ADDR_BITS-1:0]  seq_last;
    logic [1:0]            pm_nxt;
    logic                  range_nxt;
    logic                  coding_nxt;
    logic [ADDR_BITS-1:0]  chan_nxt;
    logic                  seq_on_nxt;
    logic [ADDR_BITS-1:0]  seq_last_nxt;

    assign data = (cfg_pm == PM_SHUTDOWN) ? '0 : sample;
    assign load = {1'b0, chan, data};
    assign dout = out_sr[FRAME_BITS-1];

    adc_ctrl_decode u_decode (
        .word         (in_sr),
        .pm           (cfg_pm),
        .range        (cfg_range),
        .coding       (cfg_coding),
        .chan         (chan),
        .seq_on       (seq_on),
        .seq_last     (seq_last),
        .pm_nxt       (pm_nxt),
        .range_nxt    (range_nxt),
        .coding_nxt   (coding_nxt),
        .chan_nxt     (chan_nxt),
        .seq_on_nxt   (seq_on_nxt),
        .seq_last_nxt (seq_last_nxt)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; DONE is held while cs_n stays low after a frame.
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cs_n) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cs_n)
                    state_nxt = IDLE;
                else if (count == CW'(FRAME_BITS - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                frame_done = (count == CW'(FRAME_BITS));
                if (cs_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers, bit count, abort pulse and control register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sr      <= '0;
            in_sr       <= '0;
            count       <= '0;
            frame_abort <= 1'b0;
            chan        <= '0;
            cfg_pm      <= RESET_PM;
            cfg_range   <= 1'b0;
            cfg_coding  <= 1'b0;
            seq_on      <= 1'b0;
            seq_last    <= '0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_n) begin
                        out_sr <= load;
                    end else begin
                        out_sr <= {load[FRAME_BITS-2:0], 1'b0};
                        in_sr  <= {in_sr[FRAME_BITS-2:0], din};
                        count  <= CW'(1);
                    end
                end
                SHIFT: begin
                    if (cs_n) begin
                        out_sr      <= load;
                        count       <= '0;
                        frame_abort <= 1'b1;
                    end else begin
                        out_sr <= {out_sr[FRAME_BITS-2:0], 1'b0};
                        in_sr  <= {in_sr[FRAME_BITS-2:0], din};
                        count  <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (cs_n) out_sr <= load;
                    if (frame_done) begin
                        count      <= '0;
                        cfg_pm     <= pm_nxt;
                        cfg_range  <= range_nxt;
                        cfg_coding <= coding_nxt;
                        chan       <= chan_nxt;
                        seq_on     <= seq_on_nxt;
                        seq_last   <= seq_last_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Testbench for adc_serial_responder: directed table, corner-case
// sequences and random frames against a behavioural model.
module tb_adc_serial_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        din;
    logic        dout;
    logic [11:0] sample;
    logic [2:0]  chan;
    logic [1:0]  cfg_pm;
    logic        cfg_range;
    logic        cfg_coding;
    logic        frame_done;
    logic        frame_abort;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] m_chan;
    logic [1:0] m_pm;
    logic       m_range;
    logic       m_coding;
    logic       m_seq;
    logic [2:0] m_last;

    typedef struct {
        logic [15:0] w;
        logic [11:0] s;
        logic [15:0] dout;
        logic [2:0]  chan;
        logic [1:0]  pm;
        logic        rng;
        logic        cod;
    } vec_t;

    vec_t tbl[13];

    adc_serial_responder dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .din         (din),
        .dout        (dout),
        .sample      (sample),
        .chan        (chan),
        .cfg_pm      (cfg_pm),
        .cfg_range   (cfg_range),
        .cfg_coding  (cfg_coding),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_chan = 3'd0; m_pm = 2'b11; m_range = 1'b0;
        m_coding = 1'b0; m_seq = 1'b0; m_last = 3'd0;
    endtask

    function automatic logic [15:0] m_word(input logic [11:0] s);
        return {1'b0, m_chan, (m_pm == 2'b10) ? 12'h000 : s};
    endfunction

    // Sequencer walks 0..last and wraps: modulo (last+1).
    task automatic m_apply(input logic [15:0] w);
        if (w[15]) begin
            m_pm = w[9:8]; m_range = w[5]; m_coding = w[4];
            if (w[14] && !w[7]) begin
                m_last = w[12:10]; m_chan = 3'd0; m_seq = 1'b1;
            end else begin
                m_chan = w[12:10]; m_seq = 1'b0;
            end
        end else if (m_seq) begin
            m_chan = 3'((int'(m_chan) + 1) % (int'(m_last) + 1));
        end
    endtask

    task automatic check_cfg();
        check("chan", 32'(chan), 32'(m_chan));
        check("cfg_pm", 32'(cfg_pm), 32'(m_pm));
        check("cfg_range", 32'(cfg_range), 32'(m_range));
        check("cfg_coding", 32'(cfg_coding), 32'(m_coding));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_chan"}, 32'(chan), 32'd0);
        check({tag, "_pm"}, 32'(cfg_pm), 32'd3);
        check({tag, "_range"}, 32'(cfg_range), 32'd0);
        check({tag, "_coding"}, 32'(cfg_coding), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_abort"}, 32'(frame_abort), 32'd0);
    endtask

    // Cursor convention: every task starts and ends 1 unit after posedge.
    task automatic shift_bits(input logic [15:0] w, input int n,
                              output logic [15:0] got, output int sp);
        got = '0;
        sp  = 0;
        for (int i = 0; i < n; i++) begin
            cs_n = 1'b0;
            din  = w[15-i];
            @(negedge clk);
            got[15-i] = dout;
            if (frame_done || frame_abort) sp++;
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input logic [15:0] w, input logic [11:0] s,
                         output logic [15:0] got);
        int sp;
        sample = s;
        shift_bits(w, 16, got, sp);
        cs_n = 1'b1;
        din  = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(frame_done), 32'd1);
        check("frame_quiet", 32'(sp), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_single", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic abort_frame(input logic [15:0] w, input logic [11:0] s,
                               input int n);
        logic [15:0] got;
        logic [15:0] exp;
        logic [15:0] mask;
        int sp;
        exp    = m_word(s);
        sample = s;
        shift_bits(w, n, got, sp);
        cs_n = 1'b1;
        din  = 1'b0;
        mask = 16'hFFFF << (16 - n);
        check("abort_bits", 32'(got & mask), 32'(exp & mask));
        check("abort_quiet", 32'(sp), 32'd0);
        @(negedge clk);
        check("abort_early", 32'(frame_abort), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_pulse", 32'(frame_abort), 32'd1);
        check("abort_no_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_clear", 32'(frame_abort), 32'd0);
        @(posedge clk); #1;
        check_cfg();
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] exp;
        logic [15:0] w;
        logic [11:0] s;
        int sp;

        tbl[0]  = '{16'h8700, 12'hABC, 16'h0ABC, 3'd1, 2'b11, 1'b0, 1'b0};
        tbl[1]  = '{16'h0700, 12'h123, 16'h1123, 3'd1, 2'b11, 1'b0, 1'b0};
        tbl[2]  = '{16'h8600, 12'h555, 16'h1555, 3'd1, 2'b10, 1'b0, 1'b0};
        tbl[3]  = '{16'h0000, 12'h777, 16'h1000, 3'd1, 2'b10, 1'b0, 1'b0};
        tbl[4]  = '{16'hCF00, 12'h111, 16'h1000, 3'd0, 2'b11, 1'b0, 1'b0};
        tbl[5]  = '{16'h0300, 12'h0AA, 16'h00AA, 3'd1, 2'b11, 1'b0, 1'b0};
        tbl[6]  = '{16'h0300, 12'h0BB, 16'h10BB, 3'd2, 2'b11, 1'b0, 1'b0};
        tbl[7]  = '{16'h0300, 12'h0CC, 16'h20CC, 3'd3, 2'b11, 1'b0, 1'b0};
        tbl[8]  = '{16'h0300, 12'h0DD, 16'h30DD, 3'd0, 2'b11, 1'b0, 1'b0};
        tbl[9]  = '{16'h0300, 12'h0EE, 16'h00EE, 3'd1, 2'b11, 1'b0, 1'b0};
        tbl[10] = '{16'h8730, 12'h321, 16'h1321, 3'd1, 2'b11, 1'b1, 1'b1};
        tbl[11] = '{16'hD780, 12'h0F0, 16'h10F0, 3'd5, 2'b11, 1'b0, 1'b0};
        tbl[12] = '{16'h0300, 12'h00F, 16'h500F, 3'd5, 2'b11, 1'b0, 1'b0};

        reset  = 1'b1;
        cs_n   = 1'b1;
        din    = 1'b0;
        sample = 12'h000;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            frame(tbl[i].w, tbl[i].s, got);
            m_apply(tbl[i].w);
            check("tbl_dout", 32'(got), 32'(tbl[i].dout));
            check("tbl_chan", 32'(chan), 32'(tbl[i].chan));
            check("tbl_pm", 32'(cfg_pm), 32'(tbl[i].pm));
            check("tbl_range", 32'(cfg_range), 32'(tbl[i].rng));
            check("tbl_coding", 32'(cfg_coding), 32'(tbl[i].cod));
        end

        // cs_n rises after 8 bits: abort, nothing applied, next frame ok.
        abort_frame(16'h8F00, 12'h9A5, 8);
        check("abort_chan_const", 32'(chan), 32'd5);
        exp = m_word(12'h456);
        frame(16'h0000, 12'h456, got);
        m_apply(16'h0000);
        check("post_abort_dout", 32'(got), 32'(exp));
        check("post_abort_dout_const", 32'(got), 32'h5456);
        check_cfg();

        // cs_n held low after the frame: dout 0, single done, din ignored.
        sample = 12'hFFF;
        exp = m_word(sample);
        shift_bits(16'h8B00, 16, got, sp);
        check("hold_dout", 32'(got), 32'(exp));
        for (int k = 0; k < 4; k++) begin
            cs_n = 1'b0;
            din  = 1'($urandom);
            @(negedge clk);
            check("hold_zero", 32'(dout), 32'd0);
            check("hold_done", 32'(frame_done), (k == 0) ? 32'd1 : 32'd0);
            check("hold_abort", 32'(frame_abort), 32'd0);
            @(posedge clk); #1;
        end
        cs_n = 1'b1;
        din  = 1'b0;
        @(negedge clk);
        check("hold_release", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_apply(16'h8B00);
        check_cfg();
        exp = m_word(12'h3C3);
        frame(16'h0000, 12'h3C3, got);
        m_apply(16'h0000);
        check("post_hold_dout", 32'(got), 32'(exp));

        // Random frames and aborts against the model.
        for (int r = 0; r < 40; r++) begin
            w = 16'($urandom);
            s = 12'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                abort_frame(w, s, int'($urandom_range(1, 15)));
            end else begin
                exp = m_word(s);
                frame(w, s, got);
                m_apply(w);
                check("rand_dout", 32'(got), 32'(exp));
                check_cfg();
            end
        end

        // Reset asserted at bit 7 of a frame.
        sample = 12'h5A5;
        shift_bits(16'h8F00, 7, got, sp);
        reset = 1'b1;
        cs_n  = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_quiet", 32'({frame_done, frame_abort}), 32'd0);
            @(posedge clk); #1;
        end
        frame(16'h8700, 12'hABC, got);
        m_apply(16'h8700);
        check("midrst_dout", 32'(got), 32'h0ABC);
        check("midrst_chan", 32'(chan), 32'd1);
        check_cfg();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
